// File: rtl/pack_pipe.sv
// rtl/pack_pipe.sv - narrow-to-wide packing stage with registered output word
module pack_pipe #(
  parameter int IN_W  = 32,
  parameter int RATIO = 8,
  parameter int OUT_W = IN_W * RATIO,
  parameter int CNT_W = $clog2(RATIO)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_valid_in,
  input  logic [IN_W-1:0]  f_data_in,
  input  logic             f_last_in,
  output logic             f_ready_out,
  output logic             b_valid_out,
  output logic [OUT_W-1:0] b_data_out,
  output logic [RATIO-1:0] b_keep_out,
  output logic             b_last_out,
  input  logic             b_ready_in
);

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc_data;
  logic [RATIO-1:0] acc_keep;

  logic             in_fire;
  logic             out_fire;
  logic             completing;
  logic [OUT_W-1:0] merged_data;
  logic [RATIO-1:0] merged_keep;

  // A beat can enter whenever the output register is empty or draining this cycle.
  assign f_ready_out = ~b_valid_out | b_ready_in;
  assign in_fire     = f_valid_in & f_ready_out;
  assign out_fire    = b_valid_out & b_ready_in;
  assign completing  = in_fire & ((cnt == CNT_W'(RATIO - 1)) | f_last_in);

  // Accumulator with the current beat dropped into its lane; unfilled lanes stay 0.
  always_comb begin
    merged_data                       = acc_data;
    merged_keep                       = acc_keep;
    merged_data[cnt * IN_W +: IN_W]   = f_data_in;
    merged_keep[cnt]                  = 1'b1;
  end

  // Lane counter and accumulator: advance on each beat, clear when a word closes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else if (in_fire) begin
      if (completing) begin
        cnt      <= '0;
        acc_data <= '0;
        acc_keep <= '0;
      end else begin
        cnt      <= cnt + CNT_W'(1);
        acc_data <= merged_data;
        acc_keep <= merged_keep;
      end
    end
  end

  // Output word register: load on a closing beat, drop valid once taken, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_valid_out <= 1'b0;
      b_data_out  <= '0;
      b_keep_out  <= '0;
      b_last_out  <= 1'b0;
    end else if (completing) begin
      b_valid_out <= 1'b1;
      b_data_out  <= merged_data;
      b_keep_out  <= merged_keep;
      b_last_out  <= f_last_in;
    end else if (out_fire) begin
      b_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pack_pipe.sv
// tb/tb_pack_pipe.sv - directed self-checking bench for pack_pipe
module tb_pack_pipe;
  localparam int IN_W  = 32;
  localparam int RATIO = 8;
  localparam int OUT_W = IN_W * RATIO;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             f_valid_in;
  logic [IN_W-1:0]  f_data_in;
  logic             f_last_in;
  logic             f_ready_out;
  logic             b_valid_out;
  logic [OUT_W-1:0] b_data_out;
  logic [RATIO-1:0] b_keep_out;
  logic             b_last_out;
  logic             b_ready_in;

  int checks = 0;
  int errors = 0;
  int words  = 0;
  int w0;
  logic [OUT_W-1:0] hold_word;

  pack_pipe #(.IN_W(IN_W), .RATIO(RATIO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .f_valid_in  (f_valid_in),
    .f_data_in   (f_data_in),
    .f_last_in   (f_last_in),
    .f_ready_out (f_ready_out),
    .b_valid_out (b_valid_out),
    .b_data_out  (b_data_out),
    .b_keep_out  (b_keep_out),
    .b_last_out  (b_last_out),
    .b_ready_in  (b_ready_in)
  );

  always #5 clk = ~clk;

  // Count every word handed downstream.
  always @(posedge clk) begin
    if (rst_n === 1'b1 && b_valid_out === 1'b1 && b_ready_in === 1'b1) words++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] seq_word(input logic [IN_W-1:0] base);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int i = 0; i < RATIO; i++) r[i*IN_W +: IN_W] = base + IN_W'(i);
    return r;
  endfunction

  initial begin
    rst_n      = 1'b0;
    f_valid_in = 1'b0;
    f_data_in  = '0;
    f_last_in  = 1'b0;
    b_ready_in = 1'b1;

    // Reset then idle
    tick();
    check("rst_valid_c1", OUT_W'(b_valid_out), OUT_W'(0));
    tick();
    check("rst_valid_c2", OUT_W'(b_valid_out), OUT_W'(0));
    rst_n = 1'b1;
    #1;
    check("idle_valid", OUT_W'(b_valid_out), OUT_W'(0));
    check("idle_keep", OUT_W'(b_keep_out), OUT_W'(0));
    check("idle_ready", OUT_W'(f_ready_out), OUT_W'(1));

    // Full word 0..7, last on beat 7
    for (int i = 0; i < 8; i++) begin
      f_valid_in = 1'b1;
      f_data_in  = IN_W'(i);
      f_last_in  = (i == 7);
      tick();
      if (i < 7) check("full_no_early_valid", OUT_W'(b_valid_out), OUT_W'(0));
    end
    f_valid_in = 1'b0;
    f_last_in  = 1'b0;
    check("full_valid", OUT_W'(b_valid_out), OUT_W'(1));
    check("full_data", b_data_out,
          256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
    check("full_keep", OUT_W'(b_keep_out), OUT_W'(8'hFF));
    check("full_last", OUT_W'(b_last_out), OUT_W'(1));
    tick();
    check("full_drained", OUT_W'(b_valid_out), OUT_W'(0));

    // Partial flush A,B,C then single-lane D with zero bubble
    f_valid_in = 1'b1;
    f_data_in = 32'hA; f_last_in = 1'b0; tick();
    f_data_in = 32'hB; tick();
    f_data_in = 32'hC; f_last_in = 1'b1; tick();
    check("part_valid", OUT_W'(b_valid_out), OUT_W'(1));
    check("part_data", b_data_out, 256'h0000000C_0000000B_0000000A);
    check("part_keep", OUT_W'(b_keep_out), OUT_W'(8'h07));
    check("part_last", OUT_W'(b_last_out), OUT_W'(1));
    f_data_in = 32'hD; tick();
    check("single_valid", OUT_W'(b_valid_out), OUT_W'(1));
    check("single_data", b_data_out, 256'h0000000D);
    check("single_keep", OUT_W'(b_keep_out), OUT_W'(8'h01));
    check("single_last", OUT_W'(b_last_out), OUT_W'(1));
    f_valid_in = 1'b0;
    f_last_in  = 1'b0;
    tick();
    check("single_drained", OUT_W'(b_valid_out), OUT_W'(0));

    // Backpressure: 16 beats, downstream stalls 5 cycles after the first word
    w0 = words;
    hold_word = seq_word(32'h100);
    for (int i = 0; i < 8; i++) begin
      f_valid_in = 1'b1;
      f_data_in  = 32'h100 + IN_W'(i);
      tick();
    end
    check("bp_w1_valid", OUT_W'(b_valid_out), OUT_W'(1));
    check("bp_w1_data", b_data_out, hold_word);
    b_ready_in = 1'b0;
    f_data_in  = 32'h108;
    for (int s = 0; s < 5; s++) begin
      #1;
      check("bp_stall_ready", OUT_W'(f_ready_out), OUT_W'(0));
      tick();
      check("bp_stall_valid", OUT_W'(b_valid_out), OUT_W'(1));
      check("bp_stall_data", b_data_out, hold_word);
      check("bp_stall_keep", OUT_W'(b_keep_out), OUT_W'(8'hFF));
    end
    b_ready_in = 1'b1;
    for (int i = 8; i < 16; i++) begin
      f_data_in = 32'h100 + IN_W'(i);
      tick();
      if (i == 8) check("bp_w1_taken", OUT_W'(b_valid_out), OUT_W'(0));
    end
    f_valid_in = 1'b0;
    check("bp_w2_valid", OUT_W'(b_valid_out), OUT_W'(1));
    check("bp_w2_data", b_data_out, seq_word(32'h108));
    check("bp_w2_last", OUT_W'(b_last_out), OUT_W'(0));
    tick();
    check("bp_word_count", OUT_W'(words - w0), OUT_W'(2));

    // Back-to-back: 24 beats at full rate produce 3 words, input never stalls
    w0 = words;
    for (int i = 0; i < 24; i++) begin
      f_valid_in = 1'b1;
      f_data_in  = 32'h200 + IN_W'(i);
      #1;
      check("b2b_ready", OUT_W'(f_ready_out), OUT_W'(1));
      tick();
      if (i % 8 == 7) begin
        check("b2b_valid", OUT_W'(b_valid_out), OUT_W'(1));
        check("b2b_data", b_data_out, seq_word(32'h200 + IN_W'(i - 7)));
      end
    end
    f_valid_in = 1'b0;
    tick();
    check("b2b_word_count", OUT_W'(words - w0), OUT_W'(3));

    // Back-to-back single-beat words: valid stays high for 3 consecutive cycles
    f_valid_in = 1'b1;
    f_last_in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_data_in = 32'h300 + IN_W'(i);
      tick();
      check("nobubble_valid", OUT_W'(b_valid_out), OUT_W'(1));
      check("nobubble_data", b_data_out, OUT_W'(32'h300 + i));
    end
    f_valid_in = 1'b0;
    f_last_in  = 1'b0;
    tick();
    check("nobubble_drained", OUT_W'(b_valid_out), OUT_W'(0));

    // Reset mid-word discards the partial word
    for (int i = 0; i < 5; i++) begin
      f_valid_in = 1'b1;
      f_data_in  = 32'h50 + IN_W'(i);
      tick();
    end
    f_valid_in = 1'b0;
    rst_n = 1'b0;
    tick();
    check("midrst_valid", OUT_W'(b_valid_out), OUT_W'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f_valid_in = 1'b1;
      f_data_in  = 32'h10 + IN_W'(i);
      tick();
      if (i < 7) check("midrst_no_early_valid", OUT_W'(b_valid_out), OUT_W'(0));
    end
    f_valid_in = 1'b0;
    check("midrst_data", b_data_out,
          256'h00000017_00000016_00000015_00000014_00000013_00000012_00000011_00000010);
    check("midrst_keep", OUT_W'(b_keep_out), OUT_W'(8'hFF));
    check("midrst_last", OUT_W'(b_last_out), OUT_W'(0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
